// File: rtl/shape_vote_detector.sv
`timescale 1ns/1ps
// shape_vote_detector
//   Finds the dominant colour (red or blue) in each RGB332 camera frame and
//   tracks its bounding box. It measures the object width on three scan lines
//   placed inside the previous frame's box, then classifies the frame as
//   square, triangle, diamond or none. The class is majority-voted over
//   VOTE_FRAMES frames.
//
//   Ports
//     CLK            system clock
//     RESET_N        asynchronous active-low reset
//     PIXEL_IN[7:0]  RGB332 pixel: [7:5] R, [4:2] G, [1:0] B
//     PIXEL_VALID    one-cycle strobe per new pixel
//     VGA_PIXEL_X/Y  coordinates of PIXEL_IN
//     VGA_VSYNC_NEG  high during the active frame; a falling edge ends the frame
//     RESULT[3:0]    [3] blue/red, [2] triangle, [1] square, [0] diamond
//     RESULT_VALID   one-cycle pulse when RESULT is updated
//
//   Optional macro SHAPE_VOTE_BBOX_EN adds two outputs, FIRST_LINE and
//   LAST_LINE. They carry the previous frame's box rows and read 0 while no
//   valid box exists.
module shape_vote_detector #(
    parameter int SCREEN_WIDTH  = 176,
    parameter int SCREEN_HEIGHT = 144,
    parameter int R_MIN         = 4,
    parameter int B_MIN         = 1,
    parameter int G_MAX         = 3,
    parameter int ROW_MIN       = 30,
    parameter int AREA_MIN      = 1500,
    parameter int SQ_TOL        = 10,
    parameter int VOTE_FRAMES   = 8
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic [7:0] PIXEL_IN,
    input  logic       PIXEL_VALID,
    input  logic [9:0] VGA_PIXEL_X,
    input  logic [9:0] VGA_PIXEL_Y,
    input  logic       VGA_VSYNC_NEG,
`ifdef SHAPE_VOTE_BBOX_EN
    output logic [9:0] FIRST_LINE,
    output logic [9:0] LAST_LINE,
`endif
    output logic [3:0] RESULT,
    output logic       RESULT_VALID
);
    typedef enum logic [1:0] {SCAN, CLOSE, CLASSIFY, VOTE} state_t;
    typedef enum logic [1:0] {CLS_NONE, CLS_SQ, CLS_TRI, CLS_DIA} cls_t;

    localparam logic [9:0]  SW_L   = 10'(SCREEN_WIDTH);
    localparam logic [9:0]  SH_L   = 10'(SCREEN_HEIGHT);
    localparam logic [3:0]  RMIN_L = 4'(R_MIN);
    localparam logic [3:0]  BMIN_L = 4'(B_MIN);
    localparam logic [3:0]  GMAX_L = 4'(G_MAX);
    localparam logic [7:0]  ROW_L  = 8'(ROW_MIN);
    localparam logic [15:0] AREA_L = 16'(AREA_MIN);
    localparam logic [7:0]  TOL_L  = 8'(SQ_TOL);
    localparam logic [15:0] VF_L   = 16'(VOTE_FRAMES);

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [7:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? a - b : b - a;
    endfunction

    state_t      state, state_next;
    logic        vsync_d;
    logic [9:0]  prev_y;
    logic [15:0] area_r, area_b;
    logic [7:0]  row_r, row_b;
    logic [9:0]  top_r, bot_r, top_b, bot_b;
    logic        found_r, found_b;
    logic [7:0]  w0, w1, w2;
    logic [9:0]  ptop, pbot;
    logic        box_valid, pdom_blue;
    cls_t        frame_cls;
    logic        frame_blue;
    logic [15:0] frame_cnt;
    logic [15:0] t_sq, t_tri, t_dia, bl_sq, bl_tri, bl_dia;

    // Pixel colour decode
    logic [3:0] r4, g4, b4;
    logic       red_hit, blue_hit, dom_hit, in_frame, new_row, row_close;
    logic [9:0] h, l0, l1, l2;

    always_comb begin
        r4       = {1'b0, PIXEL_IN[7:5]};
        g4       = {1'b0, PIXEL_IN[4:2]};
        b4       = {2'b00, PIXEL_IN[1:0]};
        red_hit  = (r4 >= RMIN_L) && (g4 < GMAX_L) && (r4 > ((b4 << 1) + 4'd1));
        blue_hit = !red_hit && (b4 >= BMIN_L) && (g4 < GMAX_L) && (b4 > (r4 >> 1));
        dom_hit  = pdom_blue ? blue_hit : red_hit;
        in_frame = PIXEL_VALID && (state == SCAN) && VGA_VSYNC_NEG &&
                   (VGA_PIXEL_X < SW_L) && (VGA_PIXEL_Y < SH_L);
        new_row  = in_frame && (VGA_PIXEL_Y != prev_y);
        // The last row of a frame has no following row, so CLOSE finalises it.
        row_close = new_row || (state == CLOSE);
        h  = pbot - ptop;
        l0 = ptop + (h >> 2);
        l1 = ptop + (h >> 1);
        l2 = ptop + (h >> 1) + (h >> 2);
    end

    // Frame classification
    logic red_ok, blue_ok, dom_ok, dom_blue;
    cls_t cls;

    always_comb begin
        red_ok   = area_r >= AREA_L;
        blue_ok  = area_b >= AREA_L;
        dom_ok   = red_ok || blue_ok;
        dom_blue = blue_ok && (!red_ok || (area_b > area_r));
        cls      = CLS_NONE;
        if (box_valid && dom_ok) begin
            if (abs_diff(w0, w1) <= TOL_L && abs_diff(w1, w2) <= TOL_L &&
                abs_diff(w0, w2) <= TOL_L && w1 != 8'd0)
                cls = CLS_SQ;
            else if (w1 > w0 && w1 > w2)
                cls = CLS_DIA;
            else if (w2 > w1 && w1 >= w0)
                cls = CLS_TRI;
        end
    end

    // Vote tally update and winner selection
    logic [15:0] n_sq, n_tri, n_dia, nb_sq, nb_tri, nb_dia;
    logic        publish, win_sq, win_tri, win_dia, pub_blue;

    always_comb begin
        n_sq = t_sq;  n_tri = t_tri;  n_dia = t_dia;
        nb_sq = bl_sq; nb_tri = bl_tri; nb_dia = bl_dia;
        case (frame_cls)
            CLS_SQ:  begin n_sq  = t_sq + 16'd1;  nb_sq  = bl_sq  + {15'd0, frame_blue}; end
            CLS_TRI: begin n_tri = t_tri + 16'd1; nb_tri = bl_tri + {15'd0, frame_blue}; end
            CLS_DIA: begin n_dia = t_dia + 16'd1; nb_dia = bl_dia + {15'd0, frame_blue}; end
            default: ;
        endcase
        publish = (frame_cnt + 16'd1) == VF_L;
        win_sq  = (n_sq > n_tri) && (n_sq > n_dia);
        win_tri = (n_tri > n_sq) && (n_tri > n_dia);
        win_dia = (n_dia > n_sq) && (n_dia > n_tri);
        // Blue only with a strict majority of the winner's frames; ties go to red.
        pub_blue = (win_sq  && ({nb_sq[14:0], 1'b0}  > n_sq))  ||
                   (win_tri && ({nb_tri[14:0], 1'b0} > n_tri)) ||
                   (win_dia && ({nb_dia[14:0], 1'b0} > n_dia));
    end

    always_comb begin
        state_next = state;
        case (state)
            SCAN:     if (vsync_d && !VGA_VSYNC_NEG) state_next = CLOSE;
            CLOSE:    state_next = CLASSIFY;
            CLASSIFY: state_next = VOTE;
            VOTE:     state_next = SCAN;
            default:  state_next = SCAN;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state <= SCAN;
        else          state <= state_next;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            vsync_d <= 1'b0;  prev_y <= '0;
            area_r <= '0;  area_b <= '0;  row_r <= '0;  row_b <= '0;
            top_r <= '0;  bot_r <= '0;  top_b <= '0;  bot_b <= '0;
            found_r <= 1'b0;  found_b <= 1'b0;
            w0 <= '0;  w1 <= '0;  w2 <= '0;
            ptop <= '0;  pbot <= '0;  box_valid <= 1'b0;  pdom_blue <= 1'b0;
            frame_cls <= CLS_NONE;  frame_blue <= 1'b0;  frame_cnt <= '0;
            t_sq <= '0;  t_tri <= '0;  t_dia <= '0;
            bl_sq <= '0; bl_tri <= '0; bl_dia <= '0;
            RESULT <= '0;  RESULT_VALID <= 1'b0;
        end else begin
            vsync_d      <= VGA_VSYNC_NEG;
            RESULT_VALID <= 1'b0;
            if (in_frame) begin
                prev_y <= VGA_PIXEL_Y;
                if (red_hit)  area_r <= sat_inc16(area_r);
                if (blue_hit) area_b <= sat_inc16(area_b);
                if (dom_hit && VGA_PIXEL_Y == l0) w0 <= sat_inc8(w0);
                if (dom_hit && VGA_PIXEL_Y == l1) w1 <= sat_inc8(w1);
                if (dom_hit && VGA_PIXEL_Y == l2) w2 <= sat_inc8(w2);
            end
            if (row_close) begin
                if (row_r >= ROW_L) begin
                    if (!found_r) begin top_r <= prev_y; found_r <= 1'b1; end
                    bot_r <= prev_y;
                end
                if (row_b >= ROW_L) begin
                    if (!found_b) begin top_b <= prev_y; found_b <= 1'b1; end
                    bot_b <= prev_y;
                end
                row_r <= {7'd0, in_frame && red_hit};
                row_b <= {7'd0, in_frame && blue_hit};
            end else if (in_frame) begin
                if (red_hit)  row_r <= sat_inc8(row_r);
                if (blue_hit) row_b <= sat_inc8(row_b);
            end
            // Classification stage: the box only becomes valid if a qualifying row exists.
            if (state == CLASSIFY) begin
                frame_cls  <= cls;
                frame_blue <= dom_blue;
                pdom_blue  <= dom_blue;
                box_valid  <= dom_ok && (dom_blue ? found_b : found_r);
                ptop       <= dom_blue ? top_b : top_r;
                pbot       <= dom_blue ? bot_b : bot_r;
            end
            // Vote stage
            if (state == VOTE) begin
                area_r <= '0;  area_b <= '0;  row_r <= '0;  row_b <= '0;
                top_r <= '0;  bot_r <= '0;  top_b <= '0;  bot_b <= '0;
                found_r <= 1'b0;  found_b <= 1'b0;
                w0 <= '0;  w1 <= '0;  w2 <= '0;  prev_y <= '0;
                if (publish) begin
                    RESULT       <= {pub_blue, win_tri, win_sq, win_dia};
                    RESULT_VALID <= 1'b1;
                    frame_cnt <= '0;
                    t_sq <= '0;  t_tri <= '0;  t_dia <= '0;
                    bl_sq <= '0; bl_tri <= '0; bl_dia <= '0;
                end else begin
                    frame_cnt <= frame_cnt + 16'd1;
                    t_sq <= n_sq;  t_tri <= n_tri;  t_dia <= n_dia;
                    bl_sq <= nb_sq; bl_tri <= nb_tri; bl_dia <= nb_dia;
                end
            end
        end
    end

`ifdef SHAPE_VOTE_BBOX_EN
    assign FIRST_LINE = box_valid ? ptop : 10'd0;
    assign LAST_LINE  = box_valid ? pbot : 10'd0;
`endif

endmodule

// File: tb/tb_shape_vote_detector.sv
`timescale 1ns/1ps
// Directed bench for shape_vote_detector with VOTE_FRAMES=4. It sends only
// the object pixels of each frame. Expected publications are queued when the
// final frame of a vote window ends. They are checked when RESULT_VALID pulses.
module tb_shape_vote_detector;
    logic       CLK = 1'b0;
    logic       RESET_N;
    logic [7:0] PIXEL_IN;
    logic       PIXEL_VALID;
    logic [9:0] VGA_PIXEL_X, VGA_PIXEL_Y;
    logic       VGA_VSYNC_NEG;
    logic [3:0] RESULT;
    logic       RESULT_VALID;

    shape_vote_detector #(.VOTE_FRAMES(4)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .PIXEL_IN(PIXEL_IN), .PIXEL_VALID(PIXEL_VALID),
        .VGA_PIXEL_X(VGA_PIXEL_X), .VGA_PIXEL_Y(VGA_PIXEL_Y),
        .VGA_VSYNC_NEG(VGA_VSYNC_NEG), .RESULT(RESULT), .RESULT_VALID(RESULT_VALID)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [3:0] res;
        int         due;
    } exp_t;
    exp_t sb[$];

    localparam int SH_SQ = 0, SH_TRI = 1, SH_DIA = 2, SH_GRN = 3;

    function automatic int shape_w(input int sh, input int y);
        int d;
        case (sh)
            SH_SQ:  return (y >= 52 && y <= 91) ? 40 : 0;
            SH_TRI: return (y >= 40 && y <= 99) ? y - 39 : 0;
            SH_DIA: begin
                d = (y > 72) ? y - 72 : 72 - y;
                return (d < 30) ? 60 - 2 * d : 0;
            end
            default: return (y < 10) ? 20 : 0;
        endcase
    endfunction

    function automatic logic [7:0] shape_px(input int sh);
        case (sh)
            SH_TRI:  return 8'h03;
            SH_GRN:  return 8'h1C;
            default: return 8'hE0;
        endcase
    endfunction

    task automatic check4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic send_px(input int x, input int y, input logic [7:0] p);
        PIXEL_IN = p; VGA_PIXEL_X = 10'(x); VGA_PIXEL_Y = 10'(y); PIXEL_VALID = 1'b1;
        @(posedge CLK); #1;
    endtask

    task automatic send_rows(input int sh, input int y0, input int y1);
        int w;
        for (int y = y0; y < y1; y++) begin
            w = shape_w(sh, y);
            for (int x = 88 - w / 2; x < 88 - w / 2 + w; x++) send_px(x, y, shape_px(sh));
        end
        PIXEL_VALID = 1'b0;
    endtask

    // One full frame; when pub is set the frame closes a vote window.
    task automatic run_frame(input int sh, input bit pub, input logic [3:0] exp_res);
        exp_t e;
        send_rows(sh, 0, 144);
        VGA_VSYNC_NEG = 1'b0;
        if (pub) begin
            e.res = exp_res;
            e.due = cyc + 4;
            sb.push_back(e);
        end
        repeat (8) @(posedge CLK);
        #1;
        VGA_VSYNC_NEG = 1'b1;
        @(posedge CLK); #1;
    endtask

    task automatic do_reset();
        RESET_N = 1'b0;
        @(posedge CLK); #1;
        RESET_N = 1'b1;
        @(posedge CLK); #1;
    endtask

    // Scoreboard consumer
    always @(negedge CLK) begin
        exp_t e;
        if (RESULT_VALID === 1'b1) begin
            tests++;
            assert (sb.size() != 0) else begin
                fails++;
                $error("FAIL unexpected_pulse observed=%b at cycle %0d", RESULT, cyc);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                tests++;
                assert (RESULT === e.res) else begin
                    fails++;
                    $error("FAIL pulse_result observed=%b expected=%b", RESULT, e.res);
                end
                tests++;
                assert (cyc === e.due) else begin
                    fails++;
                    $error("FAIL pulse_latency observed=%0d expected=%0d", cyc, e.due);
                end
            end
        end
    end

    initial begin
        RESET_N = 1'b0; PIXEL_IN = '0; PIXEL_VALID = 1'b0;
        VGA_PIXEL_X = '0; VGA_PIXEL_Y = '0; VGA_VSYNC_NEG = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check4("reset_result", RESULT, 4'b0000);
        check4("reset_valid", {3'b000, RESULT_VALID}, 4'b0000);
        RESET_N = 1'b1;
        @(posedge CLK); #1;

        // Red square: first frame has no prior box, then three squares.
        for (int f = 0; f < 4; f++) run_frame(SH_SQ, f == 3, 4'b0010);
        check4("square_hold", RESULT, 4'b0010);
        check4("square_valid_low", {3'b000, RESULT_VALID}, 4'b0000);

        // Continue without reset: two squares then two diamonds ties the vote.
        run_frame(SH_SQ, 1'b0, 4'b0000);
        run_frame(SH_SQ, 1'b0, 4'b0000);
        run_frame(SH_DIA, 1'b0, 4'b0000);
        run_frame(SH_DIA, 1'b1, 4'b0000);
        check4("tie_hold", RESULT, 4'b0000);

        // Blue triangle
        do_reset();
        for (int f = 0; f < 4; f++) run_frame(SH_TRI, f == 3, 4'b1100);
        check4("triangle_hold", RESULT, 4'b1100);

        // Red diamond
        do_reset();
        for (int f = 0; f < 4; f++) run_frame(SH_DIA, f == 3, 4'b0001);
        check4("diamond_hold", RESULT, 4'b0001);

        // All-green frames publish none every four frames.
        do_reset();
        for (int f = 0; f < 8; f++) run_frame(SH_GRN, (f % 4) == 3, 4'b0000);
        check4("green_hold", RESULT, 4'b0000);

        // Asynchronous reset in the middle of a frame after a square result.
        do_reset();
        for (int f = 0; f < 4; f++) run_frame(SH_SQ, f == 3, 4'b0010);
        check4("pre_reset_result", RESULT, 4'b0010);
        send_rows(SH_SQ, 0, 72);
        #2;
        RESET_N = 1'b0;
        #1;
        check4("async_reset_result", RESULT, 4'b0000);
        check4("async_reset_valid", {3'b000, RESULT_VALID}, 4'b0000);
        VGA_VSYNC_NEG = 1'b0;
        @(posedge CLK); #1;
        RESET_N = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        VGA_VSYNC_NEG = 1'b1;
        @(posedge CLK); #1;
        for (int f = 0; f < 4; f++) run_frame(SH_SQ, f == 3, 4'b0010);
        check4("post_reset_hold", RESULT, 4'b0010);

        repeat (10) @(posedge CLK);
        #1;
        tests++;
        assert (sb.size() == 0) else begin
            fails++;
            $error("FAIL missing_pulse observed=%0d pending expected=0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
